// File: rtl/clk_div_detect.sv
// Purpose : measures the period of a divided-clock waveform in clk cycles, decodes power-of-two ratios, flags lock.
// Latency : sig_in rise to period/period_valid update is SYNC_STAGES+1 clk edges; locked follows one cycle later.
// Backpr. : none; free-running measurement, ena=0 parks the block in IDLE without losing period/ratio_code.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   ena           block enable; low returns to IDLE (synchronizer keeps running)
//   sig_in        waveform under measurement, asynchronous to clk
//   period        last measured period in clk cycles
//   period_valid  one-cycle pulse when period updates
//   ratio_code    log2(period) for 2..128, else 0
//   locked        high while the last LOCK_COUNT periods are identical
//   timeout       one-cycle pulse when no edge arrives within 2^CNT_W-1 cycles
module clk_div_detect #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic [2:0]       ratio_code,
   output logic             locked,
   output logic             timeout
);

   localparam int               MW        = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
   localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_MEASURE = 1'b1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise;

   logic                   state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [MW-1:0]          match_q;
   logic                   have_prev_q;

   // Synchronizer and edge history run regardless of ena so that re-enabling
   // never sees a stale level as a fresh edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

   // cnt_q holds the number of cycles since the last detected edge, so the
   // value seen in the next detect cycle is the period itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         match_q      <= '0;
         have_prev_q  <= 1'b0;
         locked       <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         if (!ena) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
            locked      <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cnt_q       <= '0;
                  match_q     <= '0;
                  have_prev_q <= 1'b0;
                  locked      <= 1'b0;
                  if (rise) begin
                     state_q <= ST_MEASURE;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               default: begin
                  // lock is one cycle behind the match count, so a mismatch
                  // drops it in the cycle after its period_valid
                  locked <= (match_q == MATCH_MAX);
                  if (rise) begin
                     // an edge at exactly CNT_MAX wins over the timeout
                     period       <= cnt_q;
                     period_valid <= 1'b1;
                     cnt_q        <= CNT_W'(1);
                     have_prev_q  <= 1'b1;
                     if (have_prev_q && (cnt_q == period)) begin
                        if (match_q != MATCH_MAX) match_q <= match_q + MW'(1);
                     end else begin
                        match_q <= '0;
                     end
                  end else if (cnt_q == CNT_MAX) begin
                     timeout     <= 1'b1;
                     state_q     <= ST_IDLE;
                     cnt_q       <= '0;
                     match_q     <= '0;
                     have_prev_q <= 1'b0;
                     locked      <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

   // Pure decode of the registered period; 1 and non-powers of two map to 0.
   always_comb begin
      ratio_code = 3'd0;
      for (int b = 1; b < 8 && b < CNT_W; b++) begin
         if (period == (CNT_W'(1) << b)) ratio_code = 3'(b);
      end
   end

endmodule

// File: tb/tb_clk_div_detect.sv
module tb_clk_div_detect;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       sig_in;
   logic [7:0] period;
   logic       period_valid;
   logic [2:0] ratio_code;
   logic       locked;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   clk_div_detect #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .sig_in       (sig_in),
      .period       (period),
      .period_valid (period_valid),
      .ratio_code   (ratio_code),
      .locked       (locked),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   // drive one sample of sig_in, then advance to 1 time unit past the edge
   task automatic cyc(input logic v);
      sig_in = v;
      @(posedge clk);
      #1;
   endtask

   // return to IDLE with sig_in low long enough to flush the synchronizer
   task automatic park();
      sig_in = 1'b0;
      ena    = 1'b0;
      repeat (3) cyc(1'b0);
      ena = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      ena    = 1'b1;
      sig_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (period !== 8'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
      checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b exp=0", period_valid); end
      checks++; if (ratio_code !== 3'd0) begin failures++; $display("FAIL reset_ratio got=%0d exp=0", ratio_code); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
      rst_n = 1'b1;
   endtask

   // square wave of hi/lo cycles: rise k detected at k+2, first rise only arms,
   // locked one cycle after the 4th measured period
   task automatic test_steady(input string nm, input int hi, input int lo, input int nper,
                              input logic [2:0] ratio, input logic from_reset);
      int   p;
      logic exp_pv;
      logic exp_lk;
      p = hi + lo;
      park();
      for (int i = 0; i < nper * p; i++) begin
         cyc((i % p) < hi);
         exp_pv = (i >= p + 2) && (((i - 2) % p) == 0);
         exp_lk = (i >= 4 * p + 3);
         checks++; if (period_valid !== exp_pv) begin failures++; $display("FAIL %s_pv i=%0d got=%b exp=%b", nm, i, period_valid, exp_pv); end
         checks++; if (locked !== exp_lk) begin failures++; $display("FAIL %s_locked i=%0d got=%b exp=%b", nm, i, locked, exp_lk); end
         checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL %s_timeout i=%0d got=%b exp=0", nm, i, timeout); end
         if (exp_pv) begin
            checks++; if (period !== 8'(p)) begin failures++; $display("FAIL %s_period i=%0d got=%0d exp=%0d", nm, i, period, p); end
            checks++; if (ratio_code !== ratio) begin failures++; $display("FAIL %s_ratio i=%0d got=%0d exp=%0d", nm, i, ratio_code, ratio); end
         end
         if (from_reset && (i < p + 2)) begin
            checks++; if (period !== 8'd0 || ratio_code !== 3'd0) begin failures++; $display("FAIL %s_armzero i=%0d period=%0d ratio=%0d exp=0", nm, i, period, ratio_code); end
         end
      end
   endtask

   task automatic test_ratio_change();
      logic       exp_pv;
      logic       exp_lk;
      logic [7:0] exp_p;
      park();
      for (int k = 0; k < 24 + 16 * 6; k++) begin
         if (k < 24) cyc((k % 4) < 2);
         else        cyc(((k - 24) % 16) < 8);
         exp_pv = (k == 6 || k == 10 || k == 14 || k == 18 || k == 22 || k == 26) ||
                  (k >= 42 && ((k - 42) % 16) == 0);
         exp_p  = (k <= 26) ? 8'd4 : 8'd16;
         exp_lk = (k >= 19 && k <= 42) || (k >= 91);
         checks++; if (period_valid !== exp_pv) begin failures++; $display("FAIL chg_pv k=%0d got=%b exp=%b", k, period_valid, exp_pv); end
         checks++; if (locked !== exp_lk) begin failures++; $display("FAIL chg_locked k=%0d got=%b exp=%b", k, locked, exp_lk); end
         if (exp_pv) begin
            checks++; if (period !== exp_p) begin failures++; $display("FAIL chg_period k=%0d got=%0d exp=%0d", k, period, exp_p); end
            checks++; if (ratio_code !== ((exp_p == 8'd4) ? 3'd2 : 3'd4)) begin failures++; $display("FAIL chg_ratio k=%0d got=%0d", k, ratio_code); end
         end
      end
   endtask

   // rise at 0 arms, rise at 255 gives period 255, then silence until a
   // timeout at 255 cycles after that detect; later rises re-arm then measure 10
   task automatic test_timeout();
      logic exp_pv;
      logic exp_to;
      park();
      for (int k = 0; k < 545; k++) begin
         cyc((k < 4) || (k >= 255 && k < 259) || (k >= 521 && k < 525) || (k >= 531 && k < 535));
         exp_pv = (k == 257) || (k == 533);
         exp_to = (k == 512);
         checks++; if (period_valid !== exp_pv) begin failures++; $display("FAIL to_pv k=%0d got=%b exp=%b", k, period_valid, exp_pv); end
         checks++; if (timeout !== exp_to) begin failures++; $display("FAIL to_timeout k=%0d got=%b exp=%b", k, timeout, exp_to); end
         checks++; if (locked !== 1'b0) begin failures++; $display("FAIL to_locked k=%0d got=%b exp=0", k, locked); end
         if (k == 257 || k == 512) begin
            checks++; if (period !== 8'd255) begin failures++; $display("FAIL to_period255 k=%0d got=%0d exp=255", k, period); end
            checks++; if (ratio_code !== 3'd0) begin failures++; $display("FAIL to_ratio255 k=%0d got=%0d exp=0", k, ratio_code); end
         end
         if (k == 533) begin
            checks++; if (period !== 8'd10) begin failures++; $display("FAIL to_rearm_period got=%0d exp=10", period); end
         end
      end
   endtask

   task automatic test_ena_reset();
      logic exp_pv;
      logic exp_lk;
      park();
      for (int k = 0; k < 96 + 5 + 96; k++) begin
         ena = !(k >= 96 && k <= 100);
         cyc((k % 16) < 8);
         exp_pv = (k >= 18 && k <= 82 && ((k - 18) % 16) == 0) ||
                  (k >= 130 && ((k - 130) % 16) == 0);
         exp_lk = (k >= 67 && k <= 95) || (k >= 179);
         checks++; if (period_valid !== exp_pv) begin failures++; $display("FAIL ena_pv k=%0d got=%b exp=%b", k, period_valid, exp_pv); end
         checks++; if (locked !== exp_lk) begin failures++; $display("FAIL ena_locked k=%0d got=%b exp=%b", k, locked, exp_lk); end
         checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL ena_timeout k=%0d got=%b exp=0", k, timeout); end
         if (exp_pv || k == 100) begin
            checks++; if (period !== 8'd16) begin failures++; $display("FAIL ena_period k=%0d got=%0d exp=16", k, period); end
            checks++; if (ratio_code !== 3'd4) begin failures++; $display("FAIL ena_ratio k=%0d got=%0d exp=4", k, ratio_code); end
         end
      end
      // asynchronous clear away from any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (period !== 8'd0) begin failures++; $display("FAIL arst_period got=%0d exp=0", period); end
      checks++; if (ratio_code !== 3'd0) begin failures++; $display("FAIL arst_ratio got=%0d exp=0", ratio_code); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL arst_locked got=%b exp=0", locked); end
      checks++; if (period_valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL arst_pulses pv=%b to=%b exp=0", period_valid, timeout); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_steady("div8", 4, 4, 6, 3'd3, 1'b1);
      test_steady("div2", 1, 1, 8, 3'd1, 1'b0);
      test_steady("div6", 3, 3, 6, 3'd0, 1'b0);
      test_ratio_change();
      test_timeout();
      test_ena_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clk_div_detect.md
Name: clk_div_detect

Overview:
- Receive-side companion to the team's ripple clock divider.
- Takes one divided-clock waveform (e.g. clk_div2..clk_div16 or an AND of them) and measures its period in system clk cycles.
- Reports whether the period is a power-of-two divide ratio and flags lock once the period is stable.
- Sits in the Tiny Tapeout user design: sig_in comes from a ui_in pin; results drive uo_out.

Parameters:
- CNT_W, 8: width of period counter and period output; maximum measurable period is 2^CNT_W-1 (255).
- SYNC_STAGES, 2: number of flops in the sig_in synchronizer (minimum 2).
- LOCK_COUNT, 4: consecutive identical periods required to assert locked (minimum 2).

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- ena, input, 1: block enable; low synchronously returns the block to IDLE.
- sig_in, input, 1: waveform under measurement; asynchronous to clk.
- period, output, CNT_W: last measured period in clk cycles.
- period_valid, output, 1: one-cycle pulse when period updates.
- ratio_code, output, 3: log2(period) when period is 2,4,...,128; 0 otherwise.
- locked, output, 1: high while the last LOCK_COUNT measured periods are identical.
- timeout, output, 1: one-cycle pulse when no edge arrives within 2^CNT_W-1 cycles.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - period=0, ratio_code=0, period_valid=0, locked=0, timeout=0.
  - Synchronizer cleared; state=IDLE.
- Input path:
  - sig_in passes through SYNC_STAGES flops, then a previous-value register.
  - A rising edge is detected when synced=1 and prev=0.
  - Latency from sig_in rising to the detect cycle is SYNC_STAGES+1 clk edges.
  - period_valid asserts in the detect cycle, registered.
- State IDLE:
  - Cycle counter held at 0; no timeout can fire.
  - On first detected edge: go to MEASURE, counter starts. No period_valid.
- State MEASURE:
  - Counter increments every cycle.
  - On a detected edge: period <= cycles elapsed since previous edge (1..255); period_valid=1; counter restarts.
  - ratio_code updates in the same cycle as period.
  - If 255 cycles elapse with no edge: timeout pulses for 1 cycle in the cycle an edge at 255 would have reported; go to IDLE; locked=0; match count=0; period and ratio_code hold.
  - An edge exactly at 255 cycles is a valid measurement (period=255, no timeout). Edge takes priority over timeout.
- Lock tracking:
  - Match counter (saturating at LOCK_COUNT-1) increments when a new period equals the previous period.
  - Any mismatch sets the match counter to 0.
  - locked is registered: it is 1 from the cycle after the LOCK_COUNT-th consecutive equal period and stays while matches continue.
  - A mismatch, timeout, or ena=0 clears locked.
  - The first measured period after IDLE always starts a new run.
- ena=0:
  - Synchronous return to IDLE; counter=0; match=0; locked=0; period_valid=0; timeout=0.
  - period and ratio_code hold.
  - The synchronizer keeps running so edge history stays valid.
- ratio_code is purely a function of the registered period:
  - 2→1, 4→2, 8→3, 16→4, 32→5, 64→6, 128→7.
  - Any other value (including 1, 255, and non-power-of-two values) → 0.
- Mid-operation reset: asynchronous clear; after release, the first edge only arms.
- sig_in glitches shorter than one clk cycle may be missed. This is not an error condition.

Test Plan:
- Reset and arm: hold rst_n=0 for 3 cycles, release, then drive sig_in as clk/8 (4 high, 4 low) → all outputs 0 until the second detected edge; then period=8, ratio_code=3, period_valid every 8 cycles; locked=1 after the 4th period=8.
- Fastest ratio: drive sig_in toggling every clk cycle (clk/2) → period=2, ratio_code=1, period_valid every 2nd cycle, locked asserted after 4 measurements.
- Non-power-of-two: drive a period of 6 (3 high, 3 low) → period=6, ratio_code=0, locked still asserts after 4 periods.
- Ratio change: lock on clk/4, then switch to clk/16 → first period=16 drops locked the cycle after its period_valid; locked reasserts after 4 periods of 16.
- Timeout boundary: edge gap of exactly 255 cycles → period=255, ratio_code=0, no timeout. Then stop sig_in → timeout single pulse 255 cycles after the last edge; locked=0; next edge arms only.
- ena and async reset: while locked on clk/16, drop ena for 5 cycles → locked=0 and period holds 16; re-lock takes 5 edges. Then assert rst_n=0 mid-period → all outputs 0 immediately, without a clk edge.
